// File: rtl/mem_stage.sv
// Memory-access pipeline stage: merges data-SRAM read data for loads and hands results to write-back.
// Optional macro MS_LOAD_EXT_EN enables byte/halfword load select and extension; otherwise loads are word-only.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_valid_r,
    output logic [4:0]                 ms_to_ds_dest,
    output logic                       ms_we_r,
    output logic [31:0]                ms_wf_send
);

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
    logic                       rdata_held;
    logic [31:0]                rdata_h;

    logic        ms_res_from_mem;
    logic [2:0]  ms_load_type;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_pc;

    logic        ms_first;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_res_from_mem = ms_bus_r[73];
    assign ms_load_type    = ms_bus_r[72:70];
    assign ms_gr_we        = ms_bus_r[69];
    assign ms_dest         = ms_bus_r[68:64];
    assign ms_alu_result   = ms_bus_r[63:32];
    assign ms_pc           = ms_bus_r[31:0];

    // Ready-go is always 1 in this stage, so the handshake reduces to these two terms.
    assign ms_allowin     = !ms_valid || ws_allowin;
    assign ms_to_ws_valid = ms_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_bus_r <= '0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                ms_bus_r <= es_to_ms_bus;
            end
        end
    end

    // SRAM data is only valid in the first cycle, so capture it if write-back stalls then.
    assign ms_first = ms_valid && !rdata_held;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_held <= 1'b0;
            rdata_h    <= '0;
        end else if (ms_allowin) begin
            rdata_held <= 1'b0;
        end else if (ms_first) begin
            rdata_held <= 1'b1;
            rdata_h    <= data_sram_rdata;
        end
    end

    assign mem_rdata = rdata_held ? rdata_h : data_sram_rdata;

`ifdef MS_LOAD_EXT_EN
    logic [1:0]  ms_offset;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign ms_offset = ms_alu_result[1:0];

    always_comb begin
        load_byte = 8'h00;
        load_half = 16'h0000;
        load_data = mem_rdata;
        case (ms_offset)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        // Halfword alignment bit is ignored; no misalignment trap.
        load_half = ms_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ms_load_type)
            3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_data = {24'h000000, load_byte};
            3'b011:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {16'h0000, load_half};
            default: load_data = mem_rdata;
        endcase
    end
`else
    logic unused_load_type;

    assign unused_load_type = ^ms_load_type;
    assign load_data        = mem_rdata;
`endif

    assign final_result = ms_res_from_mem ? load_data : ms_alu_result;

    assign ms_to_ws_bus  = {ms_gr_we, ms_dest, final_result, ms_pc};
    assign ms_valid_r    = ms_valid;
    assign ms_to_ds_dest = ms_dest;
    assign ms_we_r       = ms_gr_we && ms_valid;
    assign ms_wf_send    = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with an expected-result queue; honours MS_LOAD_EXT_EN when defined.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_valid_r;
    logic [4:0]  ms_to_ds_dest;
    logic        ms_we_r;
    logic [31:0] ms_wf_send;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [69:0] q[$];

    typedef struct {
        logic [2:0]  lt;
        logic [31:0] addr;
        logic [31:0] rdata;
    } ld_t;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_valid_r     (ms_valid_r),
        .ms_to_ds_dest  (ms_to_ds_dest),
        .ms_we_r        (ms_we_r),
        .ms_wf_send     (ms_wf_send)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk_bus(input logic rfm, input logic [2:0] lt, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {rfm, lt, we, dest, alu, pc};
    endfunction

    // Reference load result, written from the architectural definition of each load type.
    function automatic logic [31:0] exp_load(input logic [2:0] lt, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
        h = (rd >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
`ifdef MS_LOAD_EXT_EN
        case (lt)
            3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return rd;
        endcase
`else
        return rd;
`endif
    endfunction

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, retire the head of the queue if write-back takes it.
    task automatic cycle();
        logic [69:0] e;
        @(negedge clk);
        if (ms_to_ws_valid && ws_allowin) begin
            chk("wb_expected", {73'd0, q.size() != 0}, 74'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ws_bus", {4'd0, ms_to_ws_bus}, {4'd0, e});
                chk("wf_send", {42'd0, ms_wf_send}, {42'd0, e[63:32]});
                chk("ds_dest", {69'd0, ms_to_ds_dest}, {69'd0, e[68:64]});
                chk("we_r", {73'd0, ms_we_r}, {73'd0, e[69]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] alu_v[4];
        logic [4:0]  dst_v[4];
        ld_t         lds[10];
        logic [31:0] fr;

        // Reset held with valid asserted upstream.
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = mk_bus(1'b1, 3'd1, 1'b1, 5'd9, 32'hAAAA_5555, 32'h0000_1000);
        ws_allowin      = 1'b1;
        data_sram_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {73'd0, ms_to_ws_valid}, 74'd0);
        chk("rst_allowin", {73'd0, ms_allowin}, 74'd1);
        chk("rst_bus", {4'd0, ms_to_ws_bus}, 74'd0);
        chk("rst_valid_r", {73'd0, ms_valid_r}, 74'd0);
        chk("rst_we_r", {73'd0, ms_we_r}, 74'd0);
        chk("rst_dest", {69'd0, ms_to_ds_dest}, 74'd0);
        chk("rst_wf", {42'd0, ms_wf_send}, 74'd0);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        resetn         = 1'b1;
        cycle();

        // Back-to-back ALU ops; the last carries a nonzero load_type without res_from_mem, and r0.
        alu_v = '{32'h1234_5678, 32'h8765_4321, 32'hFFFF_0000, 32'h0000_0001};
        dst_v = '{5'd5, 5'd31, 5'd12, 5'd0};
        for (int i = 0; i < 4; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(1'b0, (i == 3) ? 3'd3 : 3'd0, (i != 2), dst_v[i], alu_v[i],
                                    32'h0000_2000 + 32'(4 * i));
            q.push_back({(i != 2), dst_v[i], alu_v[i], 32'h0000_2000 + 32'(4 * i)});
            cycle();
        end
        es_to_ms_valid = 1'b0;
        cycle();
        cycle();
        chk("bubble_valid", {73'd0, ms_to_ws_valid}, 74'd0);
        chk("bubble_we_r", {73'd0, ms_we_r}, 74'd0);

        // Back-to-back loads, read data arrives the cycle after acceptance.
        lds = '{'{3'd1, 32'h1000_0003, 32'h80FF_0011},
                '{3'd2, 32'h1000_0003, 32'h80FF_0011},
                '{3'd3, 32'h1000_0002, 32'h80FF_0011},
                '{3'd4, 32'h1000_0002, 32'h80FF_0011},
                '{3'd0, 32'h1000_0001, 32'hCAFE_BABE},
                '{3'd5, 32'h1000_0000, 32'h0123_4567},
                '{3'd3, 32'h1000_0003, 32'h7F00_8001},
                '{3'd1, 32'h1000_0000, 32'h0000_0080},
                '{3'd4, 32'h1000_0001, 32'h0000_8000},
                '{3'd2, 32'h1000_0001, 32'h0000_1200}};
        for (int i = 0; i < 10; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(1'b1, lds[i].lt, 1'b1, 5'(i + 1), lds[i].addr, 32'h0000_3000 + 32'(4 * i));
            if (i > 0) data_sram_rdata = lds[i-1].rdata;
            fr = exp_load(lds[i].lt, lds[i].addr, lds[i].rdata);
            q.push_back({1'b1, 5'(i + 1), fr, 32'h0000_3000 + 32'(4 * i)});
            cycle();
        end
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = lds[9].rdata;
        cycle();
        cycle();

        // lw stalled three cycles by write-back; SRAM data goes to zero after the first.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd7, 32'h2000_0000, 32'h0000_4000);
        q.push_back({1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_4000});
        cycle();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", {73'd0, ms_to_ws_valid}, 74'd1);
            chk("stall_allowin", {73'd0, ms_allowin}, 74'd0);
            chk("stall_bus", {4'd0, ms_to_ws_bus}, {4'd0, q[0]});
            @(posedge clk);
            #1;
            data_sram_rdata = 32'h0000_0000;
        end
        // Leave and accept on the same edge: the next load must not see the held data.
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd8, 32'h2000_0004, 32'h0000_4004);
        q.push_back({1'b1, 5'd8, 32'h0BAD_F00D, 32'h0000_4004});
        cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0BAD_F00D;
        cycle();
        cycle();

        // Asynchronous reset in the middle of a stall discards the load.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd9, 32'h3000_0000, 32'h0000_5000);
        cycle();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h0000_0000;
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_valid", {73'd0, ms_to_ws_valid}, 74'd0);
        chk("arst_allowin", {73'd0, ms_allowin}, 74'd1);
        chk("arst_bus", {4'd0, ms_to_ws_bus}, 74'd0);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd10, 32'h3000_0004, 32'h0000_5004);
        q.push_back({1'b1, 5'd10, 32'h55AA_55AA, 32'h0000_5004});
        cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h55AA_55AA;
        cycle();
        cycle();

        chk("queue_drained", 74'(q.size()), 74'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
